reg_trigger_bank: RTL
=====================

// Module: reg_trigger_bank
// PURPOSE
// - Multi-channel trigger-generator register bank on the usb_reg_main bus; extends single-channel trigger regs to pNUM_CHANNELS.
// - Host writes shadow copies of per-channel delay/width/count; COMMIT atomically copies all shadows to active outputs.
// - Owns arm state machine (arm/disarm/trigger-done) and trigger-clock phase-shift handshake with timeout.
// PARAMETERS
// pBYTECNT_SIZE   7   width of reg_bytecnt
// pSELECT         2'b10  value of reg_address[7:6] decoded by this block
// pNUM_CHANNELS   4   trigger channels (1..8)
// pNUM_PULSES     8   pulses per channel
// pTIME_WIDTH     24  bits per delay and per width entry (multiple of 8)
// pCOUNT_WIDTH    4   bits of per-channel num_triggers
// pPS_TIMEOUT     255 cycles to wait for I_psdone before flagging error
// PORTS
// cwusb_clk       in   1   sole clock
// reset_i         in   1   async active-high reset
// reg_address     in   8   register address
// reg_bytecnt     in   pBYTECNT_SIZE  byte index within register
// write_data      in   8   write byte
// read_data       out  8   registered read byte
// reg_read        in   1   read strobe
// reg_write       in   1   write strobe
// reg_addrvalid   in   1   address valid
// selected        out  1   reg_addrvalid & reg_address[7:6]==pSELECT
// O_trigger_delay out  pNUM_CHANNELS*pNUM_PULSES*pTIME_WIDTH  active delays, ch0 in LSBs
// O_trigger_width out  pNUM_CHANNELS*pNUM_PULSES*pTIME_WIDTH  active widths
// O_num_triggers  out  pNUM_CHANNELS*pCOUNT_WIDTH  active pulse counts
// O_chan_enable   out  pNUM_CHANNELS  active channel enable mask
// O_arm / O_arm_pulse  out  1  armed level / 1-cycle pulse on IDLE->ARMED
// O_commit_pulse  out  1   1-cycle pulse on the cycle actives update
// I_trig_done     in   1   cwusb_clk-synchronous pulse: trigger sequence finished
// O_psen / O_psincdec  out  1  MMCM phase-shift enable / direction
// I_psdone        in   1   MMCM phase-shift done
// BEHAVIOUR
// - Addresses (address=reg_address[5:0]): 0 CHAN_SEL, 1 CHAN_ENABLE(shadow mask), 2 NUM_TRIGGERS, 3 TRIGGER_DELAY,
//   4 TRIGGER_WIDTH, 5 COMMIT, 6 ARM, 7 PHASE_SHIFT, 8 STATUS; regs 2-4 act on shadow of channel CHAN_SEL[2:0].
// - Regs 3/4 byte-addressed by reg_bytecnt: byte k = bits [8k+:8]; k >= pNUM_PULSES*pTIME_WIDTH/8 -> write ignored, read 0.
// - CHAN_SEL >= pNUM_CHANNELS: writes to 2-4 ignored, reads 0. Unmapped address: read 0, write ignored.
// - Reads: read_data registered; valid 1 cycle after reg_read; 0 when not selected.
// - Reset: all shadows/actives delay=0, width=0, num_triggers=1, enable=0; CHAN_SEL=0; read_data=0; all pulses/O_arm/O_psen/O_psincdec=0.
// - Commit: write any value to 5 sets commit_pending. Applies on first cycle with arm FSM in IDLE (next cycle if already IDLE):
//   actives<=shadows, O_commit_pulse=1, pending cleared. Shadow write in the apply cycle: active gets old shadow value.
//   Read 5: bit0 = commit_pending. Second COMMIT while pending: no additional effect.
// - Arm FSM: IDLE -(write 6 bit0)-> ARMED -(I_trig_done)-> IDLE; write 6 bit1 (disarm) -> IDLE from any state.
//   bit0&bit1 together: disarm wins. Arm write and I_trig_done same cycle: write wins. Arm in ARMED: no-op, no pulse.
//   O_arm=1 in ARMED; O_arm_pulse 1 cycle on entry. Read 6: {6'b0, commit_pending, O_arm}.
// - Phase shift FSM: PS_IDLE -(write 7)-> PS_WAIT: O_psen=1 exactly one cycle, O_psincdec<=write_data[0], timeout err cleared,
//   counter loaded pPS_TIMEOUT. PS_WAIT: I_psdone -> PS_IDLE; counter reaches 0 -> PS_IDLE, sticky ps_timeout=1.
//   Write 7 during PS_WAIT ignored (no psen). Read 7: {6'b0, ps_timeout, ps_active}.
// - STATUS (8): {pNUM_CHANNELS-1 [2:0], 3'b0, ps_active, O_arm}.
// - Async reset mid-operation: FSMs to IDLE, pending commit dropped, O_psen low immediately.
// CONFIGURATION
// - Macro TRIGGER_BANK_READBACK_ACTIVE_EN defined: CHAN_SEL bit7=1 makes reads of 1-4 return ACTIVE values
//   (writes still target shadows). Undefined: bit7 stored but ignored; reads always return shadows.
// TESTING
// - Reset -> O_num_triggers all 1, O_trigger_delay 0, O_arm 0, O_psen 0; read 2 ch0 -> 8'h01.
// - CHAN_SEL=2, write delay bytes 0..2 = 10,20,30, COMMIT -> next cycle O_trigger_delay ch2 pulse0 = 24'h1E140A,
//   O_commit_pulse 1 cycle; other channels unchanged; write byte 24 -> ignored, read byte 24 -> 0.
// - ARM=1, width write ch0, COMMIT -> read 5 = 1, actives unchanged; I_trig_done -> next cycle actives update, O_arm 0.
// - PS write 1, no psdone -> O_psen 1 cycle, O_psincdec 1, after 255 cycles read 7 = 8'h02; second write clears err.
// - ARM write 8'h03 -> stays IDLE, no O_arm_pulse; ARM=1 with I_trig_done same cycle -> ARMED.
// - With TRIGGER_BANK_READBACK_ACTIVE_EN: shadow write w/o commit, CHAN_SEL bit7=1 read -> old active; bit7=0 -> new shadow.

Source files
------------

// File: rtl/reg_trigger_bank.sv
// reg_trigger_bank: multi-channel trigger-generator register bank on the
// usb_reg_main bus. It holds a shadow copy and an active copy of each channel's
// delays, widths and pulse count. COMMIT copies every shadow into the active
// set in one cycle. The block also owns the arm state machine and the MMCM
// phase-shift handshake, which has a timeout.
//
// Optional feature: define TRIGGER_BANK_READBACK_ACTIVE_EN so that setting
// CHAN_SEL bit7 makes reads of registers 1-4 return the active values.
//
// state     | meaning
// ARM_IDLE  | not armed; a pending commit may be applied
// ARM_ARMED | armed and waiting for I_trig_done or a disarm write
// PS_IDLE   | no phase shift in flight
// PS_WAIT   | psen issued; waiting for I_psdone or the timeout
module reg_trigger_bank #(
  parameter int         pBYTECNT_SIZE = 7,
  parameter logic [1:0] pSELECT       = 2'b10,
  parameter int         pNUM_CHANNELS = 4,
  parameter int         pNUM_PULSES   = 8,
  parameter int         pTIME_WIDTH   = 24,
  parameter int         pCOUNT_WIDTH  = 4,
  parameter int         pPS_TIMEOUT   = 255
) (
  input  logic                                              cwusb_clk,
  input  logic                                              reset_i,
  input  logic [7:0]                                        reg_address,
  input  logic [pBYTECNT_SIZE-1:0]                          reg_bytecnt,
  input  logic [7:0]                                        write_data,
  output logic [7:0]                                        read_data,
  input  logic                                              reg_read,
  input  logic                                              reg_write,
  input  logic                                              reg_addrvalid,
  output logic                                              selected,
  output logic [pNUM_CHANNELS*pNUM_PULSES*pTIME_WIDTH-1:0]  O_trigger_delay,
  output logic [pNUM_CHANNELS*pNUM_PULSES*pTIME_WIDTH-1:0]  O_trigger_width,
  output logic [pNUM_CHANNELS*pCOUNT_WIDTH-1:0]             O_num_triggers,
  output logic [pNUM_CHANNELS-1:0]                          O_chan_enable,
  output logic                                              O_arm,
  output logic                                              O_arm_pulse,
  output logic                                              O_commit_pulse,
  input  logic                                              I_trig_done,
  output logic                                              O_psen,
  output logic                                              O_psincdec,
  input  logic                                              I_psdone
);

  localparam int NBYTES = pNUM_PULSES * pTIME_WIDTH / 8;
  localparam int BIDX_W = (NBYTES > 1) ? $clog2(NBYTES) : 1;
  localparam int CIDX_W = (pNUM_CHANNELS > 1) ? $clog2(pNUM_CHANNELS) : 1;
  localparam int PS_CW  = $clog2(pPS_TIMEOUT + 1);
  localparam logic [pBYTECNT_SIZE-1:0] NBYTES_B = pBYTECNT_SIZE'(NBYTES);

  localparam logic [5:0] ADDR_CHAN_SEL    = 6'd0;
  localparam logic [5:0] ADDR_CHAN_ENABLE = 6'd1;
  localparam logic [5:0] ADDR_NUM_TRIG    = 6'd2;
  localparam logic [5:0] ADDR_DELAY       = 6'd3;
  localparam logic [5:0] ADDR_WIDTH       = 6'd4;
  localparam logic [5:0] ADDR_COMMIT      = 6'd5;
  localparam logic [5:0] ADDR_ARM         = 6'd6;
  localparam logic [5:0] ADDR_PS          = 6'd7;
  localparam logic [5:0] ADDR_STATUS      = 6'd8;

  typedef enum logic {ARM_IDLE, ARM_ARMED} arm_state_t;
  typedef enum logic {PS_IDLE, PS_WAIT} ps_state_t;

  arm_state_t arm_state;
  ps_state_t  ps_state;

  logic [5:0]              addr;
  logic                    wr_en;
  logic [7:0]              chan_sel;
  logic [CIDX_W-1:0]       chan_idx;
  logic                    chan_ok;
  logic [BIDX_W-1:0]       byte_idx;
  logic                    byte_ok;
  logic                    use_active;
  logic                    commit_pending;
  logic                    commit_apply;
  logic                    arm_req;
  logic                    disarm_req;
  logic                    ps_timeout;
  logic                    ps_active;
  logic [PS_CW-1:0]        ps_cnt;
  logic [7:0]              rd_mux;

  logic [7:0]              sh_delay  [pNUM_CHANNELS][NBYTES];
  logic [7:0]              sh_width  [pNUM_CHANNELS][NBYTES];
  logic [7:0]              act_delay [pNUM_CHANNELS][NBYTES];
  logic [7:0]              act_width [pNUM_CHANNELS][NBYTES];
  logic [pCOUNT_WIDTH-1:0] sh_num    [pNUM_CHANNELS];
  logic [pCOUNT_WIDTH-1:0] act_num   [pNUM_CHANNELS];
  logic [pNUM_CHANNELS-1:0] sh_enable;

  assign addr       = reg_address[5:0];
  assign selected   = reg_addrvalid && (reg_address[7:6] == pSELECT);
  assign wr_en      = selected && reg_write;
  assign chan_idx   = chan_sel[CIDX_W-1:0];
  assign chan_ok    = {1'b0, chan_sel[2:0]} < 4'(pNUM_CHANNELS);
  assign byte_idx   = reg_bytecnt[BIDX_W-1:0];
  assign byte_ok    = reg_bytecnt < NBYTES_B;
  assign ps_active  = (ps_state == PS_WAIT);
  assign arm_req    = wr_en && (addr == ADDR_ARM) && write_data[0] && !write_data[1];
  assign disarm_req = wr_en && (addr == ADDR_ARM) && write_data[1];
  // A commit can land only while disarmed, so the trigger engine never sees a
  // timing set change in the middle of a sequence.
  assign commit_apply = commit_pending && (arm_state == ARM_IDLE);

`ifdef TRIGGER_BANK_READBACK_ACTIVE_EN
  assign use_active = chan_sel[7];
`else
  assign use_active = 1'b0;
`endif

  // Host writes to the channel select and to the shadow register set
  always_ff @(posedge cwusb_clk or posedge reset_i) begin
    if (reset_i) begin
      chan_sel  <= 8'h00;
      sh_enable <= '0;
      for (int c = 0; c < pNUM_CHANNELS; c++) begin
        sh_num[c] <= pCOUNT_WIDTH'(1);
        for (int b = 0; b < NBYTES; b++) begin
          sh_delay[c][b] <= 8'h00;
          sh_width[c][b] <= 8'h00;
        end
      end
    end else if (wr_en) begin
      case (addr)
        ADDR_CHAN_SEL:    chan_sel  <= write_data;
        ADDR_CHAN_ENABLE: sh_enable <= write_data[pNUM_CHANNELS-1:0];
        ADDR_NUM_TRIG:    if (chan_ok) sh_num[chan_idx] <= write_data[pCOUNT_WIDTH-1:0];
        ADDR_DELAY:       if (chan_ok && byte_ok) sh_delay[chan_idx][byte_idx] <= write_data;
        ADDR_WIDTH:       if (chan_ok && byte_ok) sh_width[chan_idx][byte_idx] <= write_data;
        default: ;
      endcase
    end
  end

  // Commit tracking; applying a commit copies every shadow to the active set
  always_ff @(posedge cwusb_clk or posedge reset_i) begin
    if (reset_i) begin
      commit_pending <= 1'b0;
      O_commit_pulse <= 1'b0;
      O_chan_enable  <= '0;
      for (int c = 0; c < pNUM_CHANNELS; c++) begin
        act_num[c] <= pCOUNT_WIDTH'(1);
        for (int b = 0; b < NBYTES; b++) begin
          act_delay[c][b] <= 8'h00;
          act_width[c][b] <= 8'h00;
        end
      end
    end else begin
      O_commit_pulse <= commit_apply;
      if (commit_apply) begin
        commit_pending <= 1'b0;
        O_chan_enable  <= sh_enable;
        act_num        <= sh_num;
        act_delay      <= sh_delay;
        act_width      <= sh_width;
      end else if (wr_en && (addr == ADDR_COMMIT)) begin
        commit_pending <= 1'b1;
      end
    end
  end

  // Arm state machine; disarm beats arm, and an arm write beats trigger-done
  always_ff @(posedge cwusb_clk or posedge reset_i) begin
    if (reset_i) begin
      arm_state   <= ARM_IDLE;
      O_arm       <= 1'b0;
      O_arm_pulse <= 1'b0;
    end else begin
      O_arm_pulse <= 1'b0;
      case (arm_state)
        ARM_IDLE: begin
          if (arm_req) begin
            arm_state   <= ARM_ARMED;
            O_arm       <= 1'b1;
            O_arm_pulse <= 1'b1;
          end
        end
        ARM_ARMED: begin
          if (disarm_req || (I_trig_done && !arm_req)) begin
            arm_state <= ARM_IDLE;
            O_arm     <= 1'b0;
          end
        end
        default: begin
          arm_state <= ARM_IDLE;
          O_arm     <= 1'b0;
        end
      endcase
    end
  end

  // Phase-shift handshake: one psen cycle, then wait for psdone or time out
  always_ff @(posedge cwusb_clk or posedge reset_i) begin
    if (reset_i) begin
      ps_state   <= PS_IDLE;
      O_psen     <= 1'b0;
      O_psincdec <= 1'b0;
      ps_timeout <= 1'b0;
      ps_cnt     <= '0;
    end else begin
      O_psen <= 1'b0;
      case (ps_state)
        PS_IDLE: begin
          if (wr_en && (addr == ADDR_PS)) begin
            ps_state   <= PS_WAIT;
            O_psen     <= 1'b1;
            O_psincdec <= write_data[0];
            ps_timeout <= 1'b0;
            ps_cnt     <= PS_CW'(pPS_TIMEOUT);
          end
        end
        PS_WAIT: begin
          if (I_psdone) begin
            ps_state <= PS_IDLE;
          end else if (ps_cnt <= PS_CW'(1)) begin
            ps_state   <= PS_IDLE;
            ps_timeout <= 1'b1;
            ps_cnt     <= '0;
          end else begin
            ps_cnt <= ps_cnt - PS_CW'(1);
          end
        end
        default: ps_state <= PS_IDLE;
      endcase
    end
  end

  // Read multiplexer; out-of-range channels, bytes and addresses read as zero
  always_comb begin
    rd_mux = 8'h00;
    case (addr)
      ADDR_CHAN_SEL:    rd_mux = chan_sel;
      ADDR_CHAN_ENABLE: rd_mux = 8'(use_active ? O_chan_enable : sh_enable);
      ADDR_NUM_TRIG:    if (chan_ok) rd_mux = 8'(use_active ? act_num[chan_idx] : sh_num[chan_idx]);
      ADDR_DELAY:       if (chan_ok && byte_ok)
                          rd_mux = use_active ? act_delay[chan_idx][byte_idx] : sh_delay[chan_idx][byte_idx];
      ADDR_WIDTH:       if (chan_ok && byte_ok)
                          rd_mux = use_active ? act_width[chan_idx][byte_idx] : sh_width[chan_idx][byte_idx];
      ADDR_COMMIT:      rd_mux = {7'b0, commit_pending};
      ADDR_ARM:         rd_mux = {6'b0, commit_pending, O_arm};
      ADDR_PS:          rd_mux = {6'b0, ps_timeout, ps_active};
      ADDR_STATUS:      rd_mux = {3'(pNUM_CHANNELS - 1), 3'b0, ps_active, O_arm};
      default:          rd_mux = 8'h00;
    endcase
  end

  // Registered read data, zero unless this block is being read
  always_ff @(posedge cwusb_clk or posedge reset_i) begin
    if (reset_i) read_data <= 8'h00;
    else         read_data <= (reg_read && selected) ? rd_mux : 8'h00;
  end

  // Flatten the active set onto the output buses, channel 0 in the LSBs
  for (genvar c = 0; c < pNUM_CHANNELS; c++) begin : g_chan
    assign O_num_triggers[c*pCOUNT_WIDTH +: pCOUNT_WIDTH] = act_num[c];
    for (genvar b = 0; b < NBYTES; b++) begin : g_byte
      assign O_trigger_delay[(c*NBYTES + b)*8 +: 8] = act_delay[c][b];
      assign O_trigger_width[(c*NBYTES + b)*8 +: 8] = act_width[c][b];
    end
  end

endmodule
